// File: rtl/uart_peripheral.sv
// uart_peripheral: memory-mapped 8N1 UART with a 4-entry TX FIFO, a one-byte
// RX holding register and a registered level interrupt.
// Registers: DATA +0x0, STATUS +0x4, BAUD +0x8, CTRL +0xC.
// Build option: define UART_RX_EN to compile in the receive path; without it
// uart_rx is ignored, DATA reads 0 and the RX status bits read 0.
module uart_peripheral #(
  parameter logic [31:0] base_address = 32'h40C0,
  parameter logic [15:0] default_div  = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [31:0] data_bus_data,
  input  logic [31:0] data_bus_addr,
  input  logic [1:0]  data_bus_mode,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        uart_irq
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Bus decode; address bits [1:0] are ignored.
  logic [31:0] offset;
  logic        hit, rd_en, wr_en;
  logic [1:0]  sel;
  logic [31:0] wdata, rdata;
  logic        wr_data, wr_status, wr_baud, wr_ctrl, rd_data;

  assign offset    = data_bus_addr - base_address;
  assign hit       = (offset[31:4] == 28'd0);
  assign sel       = offset[3:2];
  assign rd_en     = hit && (data_bus_mode == 2'b01);
  assign wr_en     = hit && (data_bus_mode == 2'b10);
  assign wdata     = data_bus_data;
  assign wr_data   = wr_en && (sel == 2'd0);
  assign wr_status = wr_en && (sel == 2'd1);
  assign wr_baud   = wr_en && (sel == 2'd2);
  assign wr_ctrl   = wr_en && (sel == 2'd3);
  assign rd_data   = rd_en && (sel == 2'd0);

  logic [15:0] div, div_eff;
  logic [1:0]  ctrl;
  assign div_eff = (div == 16'd0) ? 16'd1 : div;

  // Configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= default_div;
      ctrl <= 2'b00;
    end else begin
      if (wr_baud) div  <= wdata[15:0];
      if (wr_ctrl) ctrl <= wdata[1:0];
    end
  end

  // TX FIFO: fullness is judged before the edge, so a push on a full FIFO is
  // dropped even when the FSM pops in the same cycle.
  logic [7:0] fifo_mem [4];
  logic [1:0] wptr, rptr;
  logic [2:0] count;
  logic       tx_full, tx_empty, push, pop;

  assign tx_full  = (count == 3'd4);
  assign tx_empty = (count == 3'd0);
  assign push     = wr_data && !tx_full;

  // FIFO storage (no reset needed; validity tracked by count).
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= wdata[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // TX FSM.
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tc, tx_busy;

  assign tx_tc   = (tx_cnt == 16'd0);
  assign tx_busy = (tx_state != TX_IDLE);

  // TX state register.
  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  // TX next state, FIFO pop and serial output.
  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    uart_tx = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          pop     = 1'b1;
          tx_next = TX_START;
        end
      end
      TX_START: begin
        uart_tx = 1'b0;
        if (tx_tc) tx_next = TX_DATA;
      end
      TX_DATA: begin
        uart_tx = tx_shift[0];
        if (tx_tc && (tx_bit == 3'd7)) tx_next = TX_STOP;
      end
      TX_STOP: begin
        if (tx_tc) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX bit timer and shifter; the divisor is reloaded at every bit boundary
  // so a BAUD change lands on the next bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
    end else if (tx_state == TX_IDLE) begin
      if (pop) begin
        tx_shift <= fifo_mem[rptr];
        tx_cnt   <= div_eff - 16'd1;
        tx_bit   <= 3'd0;
      end
    end else begin
      tx_cnt <= tx_tc ? (div_eff - 16'd1) : (tx_cnt - 16'd1);
      if ((tx_state == TX_DATA) && tx_tc) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun, frame_err;
  logic       unused_bits;
  assign unused_bits = ^{offset[1:0], wdata[31:16]};

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state, rx_next;
  logic        rx_s1, rx_s2, rx_prev, rx_fall;
  logic [15:0] rx_cnt, rx_half;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tc, rx_done, rx_ferr;

  assign rx_fall = rx_prev && !rx_s2;
  assign rx_tc   = (rx_cnt == 16'd0);
  assign rx_half = ((div_eff >> 1) == 16'd0) ? 16'd1 : (div_eff >> 1);

  // Two-flop synchronizer plus edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // RX next state and completion strobes.
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    rx_ferr = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tc) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tc && (rx_bit == 3'd7)) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_tc) begin
          rx_next = RX_IDLE;
          if (rx_s2) rx_done = 1'b1;
          else       rx_ferr = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // RX sample timer and shifter: half a bit to the start-bit centre, then
  // one full bit per sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else if (rx_state == RX_IDLE) begin
      if (rx_fall) rx_cnt <= rx_half - 16'd1;
    end else begin
      rx_cnt <= rx_tc ? (div_eff - 16'd1) : (rx_cnt - 16'd1);
      if ((rx_state == RX_START) && rx_tc) rx_bit <= 3'd0;
      if ((rx_state == RX_DATA) && rx_tc) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // Holding register and sticky flags; a new byte beats a same-cycle read,
  // and a flag being set beats a same-cycle write-one-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_done) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
      if (rx_done && rx_valid && !rd_data) rx_overrun <= 1'b1;
      else if (wr_status && wdata[3])      rx_overrun <= 1'b0;
      if (rx_ferr)                         frame_err <= 1'b1;
      else if (wr_status && wdata[4])      frame_err <= 1'b0;
    end
  end
`else
  logic unused_rx;
  assign unused_rx  = ^{uart_rx, wr_status, rd_data, wdata[4:3]};
  assign rx_byte    = 8'd0;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign frame_err  = 1'b0;
`endif

  // Read mux; the bus is driven only during a matching read.
  always_comb begin
    rdata = 32'd0;
    case (sel)
      2'd0: rdata = {24'd0, rx_byte};
      2'd1: rdata = {26'd0, tx_busy, frame_err, rx_overrun, rx_valid, tx_empty, tx_full};
      2'd2: rdata = {16'd0, div};
      2'd3: rdata = {30'd0, ctrl};
      default: rdata = 32'd0;
    endcase
  end

  assign data_bus_data = rd_en ? rdata : {32{1'bz}};

  // Registered interrupt request.
  always_ff @(posedge clk) begin
    if (reset) uart_irq <= 1'b0;
    else       uart_irq <= (ctrl[0] && tx_empty && !tx_busy) || (ctrl[1] && rx_valid);
  end

endmodule
